coreid_multi: RTL and testbench
===============================

# coreid_multi

Parametrised ZX-UNO identification-string server that exposes NUM_STR read-only ASCII strings, such as core ID, build date and board revision, on consecutive ZX-UNO register addresses starting at BASE_ADDR. Each string has its own byte pointer. Successive reads of a register stream that string byte by byte. A write to a register seeks its pointer. The block sits on the ZX-UNO register bus beside the other register peripherals, and its dout/oe_n feed the bus read multiplexer.

## Interface
Parameters:
- NUM_STR, 4: number of strings / registers (1..16).
- STR_LEN, 16: bytes per string; power of two, 2..256. IDX_W = log2(STR_LEN).
- BASE_ADDR, 8'hFC: register address of string 0. String k is at BASE_ADDR+k; BASE_ADDR+NUM_STR-1 must be ≤ 8'hFF.
- WRAP, 1: 1 = pointer wraps STR_LEN-1 → 0; 0 = pointer saturates at STR_LEN-1.
- STOP_AT_NUL, 1: 1 = pointer does not advance past a byte equal to 8'h00.
- STR_INIT, all zero: packed NUM_STR*STR_LEN*8 bits. Byte j of string k is STR_INIT[(k*STR_LEN+j)*8 +: 8].

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- zxuno_addr, input, 8: currently selected ZX-UNO register address.
- zxuno_regrd, input, 1: register read strobe, high for the duration of a read access.
- zxuno_regwr, input, 1: register write strobe, high for the duration of a write access.
- din, input, 8: write data.
- regaddr_changed, input, 1: one-cycle pulse when zxuno_addr is rewritten.
- dout, output, 8: read data; 8'h00 when oe_n=1.
- oe_n, output, 1: active-low output enable for the bus read mux.

## Operation
- hit = zxuno_addr in [BASE_ADDR, BASE_ADDR+NUM_STR-1]; sel = zxuno_addr − BASE_ADDR.
- Storage: ROM built from STR_INIT; not writable at run time.
- Per string k: idx[k] (IDX_W bits) plus a reading[k] flag.
- oe_n = !(hit && zxuno_regrd), combinational. dout = rom[sel][idx[sel]] when oe_n=0, else 8'h00.
- Read advance: when oe_n=0, reading[sel] is set. On the first cycle where reading[k]=1 and (oe_n=1 or sel≠k), reading[k] is cleared and idx[k] advances.
- Advance rule:
  - If STOP_AT_NUL=1 and rom[k][idx[k]]==8'h00, idx holds.
  - Else if idx==STR_LEN-1, idx becomes 0 when WRAP=1 and holds when WRAP=0.
  - Else idx increments by 1.
- Seek: a rising edge of (hit && zxuno_regwr) loads idx[sel] <= din[IDX_W-1:0] and clears reading[sel]. The write strobe is registered for edge detection, so exactly one load occurs per access.
- Rewind: regaddr_changed=1 with hit=1 clears idx[sel] and reading[sel]. Other strings are untouched.
- Priority per string, highest first: rst, rewind, seek, read advance.
- A rewind or seek during an in-progress read cancels that read's advance.
- Non-hit addresses: no state change, oe_n=1.

## Timing
- Reset, asynchronous: all idx=0, all reading=0, regwr edge register=0.
- Outputs after reset: oe_n=1 and dout=8'h00 whenever regrd is low. The combinational path still applies: regrd=1 on a hit address during or after reset gives oe_n=0, dout=rom[sel][0].
- Read data is combinational from zxuno_addr, zxuno_regrd and idx: zero-cycle latency, stable for the whole strobe.
- Pointer update lands on the clk edge one cycle after the read strobe falls. The next read may begin the cycle after that.
- Back-to-back reads separated by fewer than one idle cycle are not supported.
- Seek and rewind take effect on the next clk edge. A read starting one cycle later sees the new byte.

## Test plan
- Reset, then string 0 = "T20-ZXUNO" at 8'hFC: 9 reads return 'T','2','0',…,'O'. Further reads return 8'h00 repeatedly with STOP_AT_NUL=1, and idx stays 9.
- WRAP=1, STOP_AT_NUL=0, STR_LEN=4, string "ABCD": 6 reads give A,B,C,D,A,B. With WRAP=0 the same reads give A,B,C,D,D,D.
- Interleaving: read string 0 twice, read string 1 once, read string 0 again. Result: s0[0], s0[1], s1[0], s0[2]; pointers are independent.
- Seek: write 8'h05 to 8'hFD, then read → s1[5]. Write with din=8'h13 at STR_LEN=16 → idx=3.
- Rewind: after 3 reads of 8'hFE, pulse regaddr_changed with addr=8'hFE, then read → s2[0]. Pulse with addr=8'h40 → no pointer change.
- Async reset: assert rst mid-read with strobe high. All pointers are 0 immediately, no advance occurs after the strobe falls, and the next read returns byte 0.

Source files
------------

// File: rtl/coreid_multi.sv
// coreid_multi: NUM_STR read-only ID strings streamed byte by byte over ZX-UNO registers
module coreid_multi #(
    parameter int NUM_STR     = 4,
    parameter int STR_LEN     = 16,
    parameter logic [7:0] BASE_ADDR = 8'hFC,
    parameter bit WRAP        = 1'b1,
    parameter bit STOP_AT_NUL = 1'b1,
    parameter logic [NUM_STR*STR_LEN*8-1:0] STR_INIT = '0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic [7:0] din,
    input  logic       regaddr_changed,
    output logic [7:0] dout,
    output logic       oe_n
);
    localparam int IDX_W = $clog2(STR_LEN);
    localparam int SEL_W = NUM_STR > 1 ? $clog2(NUM_STR) : 1;

    logic [8:0]       off;
    logic             hit;
    logic [SEL_W-1:0] sel;
    logic             wr_q, wr_d;
    logic [IDX_W-1:0] idx_q [NUM_STR];
    logic [IDX_W-1:0] idx_d [NUM_STR];
    logic             rd_q  [NUM_STR];
    logic             rd_d  [NUM_STR];
    logic [7:0]       cur   [NUM_STR];

    // 9-bit difference so addresses below BASE_ADDR wrap to large values and miss
    assign off  = {1'b0, zxuno_addr} - {1'b0, BASE_ADDR};
    assign hit  = off < 9'(NUM_STR);
    assign sel  = off[SEL_W-1:0];
    assign oe_n = !(hit && zxuno_regrd);
    assign dout = oe_n ? 8'h00 : cur[sel];
    assign wr_d = hit && zxuno_regwr;

    for (genvar k = 0; k < NUM_STR; k++) begin : g_str
        logic             me, act, adv, sk, rw;
        logic [IDX_W-1:0] nxt;
        assign cur[k] = STR_INIT[(k*STR_LEN + int'(idx_q[k]))*8 +: 8];
        assign me  = hit && sel == SEL_W'(k);
        assign act = me && zxuno_regrd;
        assign adv = rd_q[k] && !act;
        assign sk  = me && zxuno_regwr && !wr_q;
        assign rw  = me && regaddr_changed;
        assign nxt = (STOP_AT_NUL && cur[k] == 8'h00) ? idx_q[k] :
                     (idx_q[k] == IDX_W'(STR_LEN-1)) ? (WRAP ? '0 : idx_q[k]) :
                     idx_q[k] + 1'b1;
        assign idx_d[k] = rw ? '0 : sk ? din[IDX_W-1:0] : adv ? nxt : idx_q[k];
        // reading simply tracks whether this string was driven onto the bus this cycle
        assign rd_d[k]  = act && !rw && !sk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= 1'b0;
            for (int k = 0; k < NUM_STR; k++) begin
                idx_q[k] <= '0;
                rd_q[k]  <= 1'b0;
            end
        end else begin
            wr_q <= wr_d;
            for (int k = 0; k < NUM_STR; k++) begin
                idx_q[k] <= idx_d[k];
                rd_q[k]  <= rd_d[k];
            end
        end
    end
endmodule

// File: tb/tb_coreid_multi.sv
// tb_coreid_multi: scoreboard bench for coreid_multi against a pointer-per-string reference model
module tb_coreid_multi;
    function automatic logic [511:0] mk(input logic [127:0] a, input logic [127:0] b,
                                        input logic [127:0] c, input logic [127:0] d);
        logic [3:0][127:0] s;
        logic [511:0] r;
        s = {d, c, b, a};
        r = '0;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 16; n++)
                if (s[k][127:120] == 8'h00) s[k] = s[k] << 8;
            for (int j = 0; j < 16; j++) r[(k*16+j)*8 +: 8] = s[k][(15-j)*8 +: 8];
        end
        return r;
    endfunction

    localparam logic [511:0] P0 = mk(128'("T20-ZXUNO"), 128'("BUILD 2024-06-01"),
                                     128'("REV B"), 128'("ZXUNO+ 4MB"));
    localparam logic [31:0] ABCD = 32'h44434241;

    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] zxuno_addr = 8'h00, din = 8'h00;
    logic       zxuno_regrd = 1'b0, zxuno_regwr = 1'b0, regaddr_changed = 1'b0;
    logic [7:0] d0, d1, d2;
    logic       o0, o1, o2;
    logic [7:0] dout_all;
    logic       oe_all;
    int         vecs = 0, errs = 0;
    logic [7:0] q[$];
    int         ptr[6];
    bit         mon_en = 1'b0, in_rd = 1'b0;
    logic [7:0] cur_e;

    always #5 clk = ~clk;

    coreid_multi #(.STR_INIT(P0)) u_main (
        .clk(clk), .rst(rst), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
        .zxuno_regwr(zxuno_regwr), .din(din), .regaddr_changed(regaddr_changed),
        .dout(d0), .oe_n(o0));
    coreid_multi #(.NUM_STR(1), .STR_LEN(4), .BASE_ADDR(8'h10), .WRAP(1'b1),
                   .STOP_AT_NUL(1'b0), .STR_INIT(ABCD)) u_wrap (
        .clk(clk), .rst(rst), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
        .zxuno_regwr(zxuno_regwr), .din(din), .regaddr_changed(regaddr_changed),
        .dout(d1), .oe_n(o1));
    coreid_multi #(.NUM_STR(1), .STR_LEN(4), .BASE_ADDR(8'h20), .WRAP(1'b0),
                   .STOP_AT_NUL(1'b0), .STR_INIT(ABCD)) u_sat (
        .clk(clk), .rst(rst), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
        .zxuno_regwr(zxuno_regwr), .din(din), .regaddr_changed(regaddr_changed),
        .dout(d2), .oe_n(o2));

    // bus read mux: disabled peripherals drive zero
    assign dout_all = d0 | d1 | d2;
    assign oe_all   = o0 & o1 & o2;

    // reference model: strings 0..3 main block, 4 = wrapping ABCD, 5 = saturating ABCD
    function automatic int lk(input logic [7:0] a);
        if (a >= 8'hFC) return int'(a) - 252;
        if (a == 8'h10) return 4;
        if (a == 8'h20) return 5;
        return -1;
    endfunction
    function automatic int slen(input int i);
        return i < 4 ? 16 : 4;
    endfunction
    function automatic logic [7:0] rb(input int i, input int j);
        return i < 4 ? P0[(i*16+j)*8 +: 8] : ABCD[j*8 +: 8];
    endfunction
    function automatic int after(input int i, input int p);
        if (i < 4 && rb(i, p) == 8'h00) return p;
        if (p == slen(i) - 1) return i == 5 ? p : 0;
        return p + 1;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %02h, need %02h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a);
        int i = lk(a);
        if (i >= 0) begin
            q.push_back(rb(i, ptr[i]));
            ptr[i] = after(i, ptr[i]);
        end
        zxuno_addr = a;
        zxuno_regrd = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        zxuno_regrd = 1'b0;
        step();
        repeat ($urandom_range(0, 1)) step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        int i = lk(a);
        if (i >= 0) ptr[i] = int'(d) % slen(i);
        zxuno_addr = a;
        din = d;
        zxuno_regwr = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        zxuno_regwr = 1'b0;
        step();
    endtask

    task automatic chg(input logic [7:0] a);
        int i = lk(a);
        if (i >= 0) ptr[i] = 0;
        zxuno_addr = a;
        regaddr_changed = 1'b1;
        step();
        regaddr_changed = 1'b0;
        step();
    endtask

    // monitor: one expected byte per read strobe, held for the whole strobe
    always @(negedge clk) begin
        if (mon_en && !oe_all) begin
            if (!in_rd) begin
                in_rd = 1'b1;
                cur_e = q.size() > 0 ? q.pop_front() : 8'hxx;
            end
            chk($sformatf("read@%02h", zxuno_addr), dout_all, cur_e);
        end else in_rd = 1'b0;
    end

    initial begin
        logic [7:0] addrs[7] = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h10, 8'h20, 8'h40};
        foreach (ptr[i]) ptr[i] = 0;
        #3;
        chk("rst_oe", {7'b0, oe_all}, 8'h01);
        chk("rst_dout", dout_all, 8'h00);
        zxuno_addr = 8'hFC;
        zxuno_regrd = 1'b1;
        #1;
        chk("rst_rd_oe", {7'b0, oe_all}, 8'h00);
        chk("rst_rd_dout", dout_all, 8'h54);
        zxuno_regrd = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        mon_en = 1'b1;
        repeat (11) rd(8'hFC);
        repeat (6) rd(8'h10);
        repeat (6) rd(8'h20);
        chg(8'hFC);
        rd(8'hFC); rd(8'hFC); rd(8'hFD); rd(8'hFC);
        wr(8'hFD, 8'h05); rd(8'hFD);
        wr(8'hFD, 8'h13); rd(8'hFD);
        repeat (3) rd(8'hFE);
        chg(8'hFE); rd(8'hFE);
        rd(8'hFE); chg(8'h40); rd(8'hFE);
        for (int n = 0; n < 300; n++) begin
            int op = $urandom_range(0, 7);
            int s = $urandom_range(0, 7);
            logic [7:0] a = s == 7 ? 8'($urandom) : addrs[s];
            if (op < 6) rd(a);
            else if (op == 6) wr(a, 8'($urandom));
            else chg(a);
        end
        wr(8'hFD, 8'h07);
        mon_en = 1'b0;
        zxuno_addr = 8'hFD;
        zxuno_regrd = 1'b1;
        #1;
        chk("pre_arst", dout_all, rb(1, 7));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_dout", dout_all, rb(1, 0));
        chk("arst_oe", {7'b0, oe_all}, 8'h00);
        step();
        zxuno_regrd = 1'b0;
        #1;
        chk("arst_idle_oe", {7'b0, oe_all}, 8'h01);
        chk("arst_idle_dout", dout_all, 8'h00);
        step();
        rst = 1'b0;
        foreach (ptr[i]) ptr[i] = 0;
        step();
        mon_en = 1'b1;
        rd(8'hFD); rd(8'hFD); rd(8'hFC); rd(8'h10); rd(8'h20);
        step();
        chk("queue_empty", 8'(q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
